// File: rtl/tap_pkg.sv
// Shared types, constants and elaboration helpers for the tap-window sequencer.
// Pure declarations: no logic, no latency, no flow control.
package tap_pkg;

   localparam int DEF_SIZE = 5;
   localparam int HALF     = (DEF_SIZE - 1) / 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2,
      HBLANK = 2'd3
   } state_t;

   localparam int EDGE_L = 0;
   localparam int EDGE_R = 1;
   localparam int EDGE_T = 2;
   localparam int EDGE_B = 3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int win_half(input int size);
      return (size - 1) / 2;
   endfunction

endpackage

// File: rtl/tap_axis_cnt.sv
// Saturating axis counter with border flags evaluated on the post-clear value.
// Flags are combinational on cur; count updates next cycle; never stalls.
module tap_axis_cnt
   import tap_pkg::*;
#(
   parameter int W     = 12,
   parameter int LIMIT = 1920,
   parameter int HW    = HALF
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cur,
   output logic         lo,
   output logic         hi,
   output logic         is_last,
   output logic         at_lim
);

   localparam logic [W-1:0] MAX   = {W{1'b1}};
   localparam logic [W-1:0] LO_TH = W'(HW);
   localparam logic [W-1:0] HI_TH = W'(LIMIT - 1 - HW);
   localparam logic [W-1:0] LAST  = W'(LIMIT - 1);
   localparam logic [W-1:0] LIM   = W'(LIMIT);

   // A clear in the same cycle as an increment restarts the count at one,
   // so the pixel that opens a new line or frame is itself counted.
   always_comb begin
      cur = clr ? '0 : cnt;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cur != MAX)) begin
         cnt <= cur + W'(1);
      end else begin
         cnt <= cur;
      end
   end

   assign lo      = (cur < LO_TH);
   assign hi      = (cur > HI_TH);
   assign is_last = (cur == LAST);
   assign at_lim  = (cnt == LIM);

endmodule

// File: rtl/tap_window_ctrl.sv
// Frame/line sequencer: window centre coordinates, border flags, pulses, geometry errors.
// One-cycle registered latency from tap_vs/tap_de; observes only, never backpressures.
module tap_window_ctrl
   import tap_pkg::*;
#(
   parameter int SIZE         = 5,
   parameter int VIDEO_WIDTH  = 1920,
   parameter int VIDEO_HEIGHT = 1080,
   parameter int XW           = 12,
   parameter int YW           = 12
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          tap_vs,
   input  logic          tap_de,
   output logic [XW-1:0] col,
   output logic [YW-1:0] row,
   output logic          win_de,
   output logic          win_valid,
   output logic [3:0]    win_edge,
   output logic          sof,
   output logic          eof,
   output logic          sol,
   output logic          eol,
   output logic          line_err,
   output logic          frame_err
);

   localparam int HW = win_half(SIZE);

   if (XW < clog2(VIDEO_WIDTH + 1) || YW < clog2(VIDEO_HEIGHT + 1)) begin : g_bad_width
      $error("tap_window_ctrl: XW/YW too narrow for the configured geometry");
   end
   if ((SIZE < 3) || ((SIZE % 2) == 0)) begin : g_bad_size
      $error("tap_window_ctrl: SIZE must be odd and at least 3");
   end

   state_t state;
   state_t state_nxt;
   logic   vs_d;
   logic   vs_rise;
   logic   pix;
   logic   closing;

   logic [XW-1:0] col_cnt;
   logic [XW-1:0] col_cur;
   logic          col_lo;
   logic          col_hi;
   logic          col_last;
   logic          col_at_lim;
   logic [YW-1:0] row_cnt;
   logic [YW-1:0] row_cur;
   logic          row_lo;
   logic          row_hi;
   logic          row_last;
   logic          row_at_lim;

   logic [XW-1:0] col_d;
   logic [YW-1:0] row_d;
   logic [3:0]    edge_raw;
   logic [3:0]    edge_d;
   logic          de_d;
   logic          valid_d;
   logic          sof_d;
   logic          eof_d;
   logic          sol_d;
   logic          eol_d;
   logic          lerr_d;
   logic          ferr_d;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) vs_d <= 1'b0;
      else        vs_d <= tap_vs;
   end

   assign vs_rise = tap_vs & ~vs_d;
   assign pix     = tap_de & (state != IDLE);
   // A vs rise while a line is still open closes that line before the new frame.
   assign closing = (state == ACTIVE) & (~tap_de | vs_rise);

   tap_axis_cnt #(
      .W     (XW),
      .LIMIT (VIDEO_WIDTH),
      .HW    (HW)
   ) u_col_cnt (
      .clock   (clock),
      .rst_n   (rst_n),
      .clr     (closing),
      .inc     (pix),
      .cnt     (col_cnt),
      .cur     (col_cur),
      .lo      (col_lo),
      .hi      (col_hi),
      .is_last (col_last),
      .at_lim  (col_at_lim)
   );

   tap_axis_cnt #(
      .W     (YW),
      .LIMIT (VIDEO_HEIGHT),
      .HW    (HW)
   ) u_row_cnt (
      .clock   (clock),
      .rst_n   (rst_n),
      .clr     (vs_rise),
      .inc     (closing & ~vs_rise),
      .cnt     (row_cnt),
      .cur     (row_cur),
      .lo      (row_lo),
      .hi      (row_hi),
      .is_last (row_last),
      .at_lim  (row_at_lim)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (vs_rise) state_nxt = VBLANK;
         VBLANK:  if (tap_de)  state_nxt = ACTIVE;
         ACTIVE:  if (!tap_de) state_nxt = HBLANK;
         HBLANK:  if (tap_de)  state_nxt = ACTIVE;
         default: state_nxt = IDLE;
      endcase
      // The pixel coinciding with a vs rise is already counted, so stay in ACTIVE.
      if ((state != IDLE) && vs_rise) begin
         state_nxt = tap_de ? ACTIVE : VBLANK;
      end
   end

   always_comb begin
      edge_raw         = '0;
      edge_raw[EDGE_L] = col_lo;
      edge_raw[EDGE_R] = col_hi;
      edge_raw[EDGE_T] = row_lo;
      edge_raw[EDGE_B] = row_hi;

      de_d    = pix;
      edge_d  = pix ? edge_raw : 4'b0000;
      valid_d = pix & ~|edge_raw;
      col_d   = pix ? col_cur : col;
      row_d   = pix ? row_cur : row;
      sol_d   = pix & (col_cur == '0);
      eol_d   = pix & col_last;
      sof_d   = sol_d & (row_cur == '0);
      eof_d   = eol_d & row_last;
      lerr_d  = closing & ~col_at_lim;
      ferr_d  = 1'b0;
      if (vs_rise && ((state == ACTIVE) || (state == HBLANK))) begin
         // From ACTIVE the closing line has not yet been added to row_cnt.
         ferr_d = (state == ACTIVE) ? (row_cnt != YW'(VIDEO_HEIGHT - 1)) : ~row_at_lim;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         win_de    <= 1'b0;
         win_valid <= 1'b0;
         win_edge  <= 4'b0000;
         sof       <= 1'b0;
         eof       <= 1'b0;
         sol       <= 1'b0;
         eol       <= 1'b0;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         col       <= col_d;
         row       <= row_d;
         win_de    <= de_d;
         win_valid <= valid_d;
         win_edge  <= edge_d;
         sof       <= sof_d;
         eof       <= eof_d;
         sol       <= sol_d;
         eol       <= eol_d;
         line_err  <= lerr_d;
         frame_err <= ferr_d;
      end
   end

endmodule

// File: tb/tb_tap_window_ctrl.sv
// Bench: 5x5 window on an 8x6 image (instance a) and 3x3 window on a 4x4 image (instance b).
module tb_tap_window_ctrl;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   logic vs_a = 1'b0, de_a = 1'b0, vs_b = 1'b0, de_b = 1'b0;

   logic [3:0] col_a, row_a;
   logic       win_de_a, win_valid_a, sof_a, eof_a, sol_a, eol_a, line_err_a, frame_err_a;
   logic [3:0] win_edge_a;
   logic [2:0] col_b, row_b;
   logic       win_de_b, win_valid_b, sof_b, eof_b, sol_b, eol_b, line_err_b, frame_err_b;
   logic [3:0] win_edge_b;

   int n_chk = 0;
   int n_err = 0;
   int valid_cnt = 0;

   always #5 clock = ~clock;

   tap_window_ctrl #(.SIZE(5), .VIDEO_WIDTH(8), .VIDEO_HEIGHT(6), .XW(4), .YW(4)) dut_a (
      .clock(clock), .rst_n(rst_n), .tap_vs(vs_a), .tap_de(de_a),
      .col(col_a), .row(row_a), .win_de(win_de_a), .win_valid(win_valid_a),
      .win_edge(win_edge_a), .sof(sof_a), .eof(eof_a), .sol(sol_a), .eol(eol_a),
      .line_err(line_err_a), .frame_err(frame_err_a)
   );

   tap_window_ctrl #(.SIZE(3), .VIDEO_WIDTH(4), .VIDEO_HEIGHT(4), .XW(3), .YW(3)) dut_b (
      .clock(clock), .rst_n(rst_n), .tap_vs(vs_b), .tap_de(de_b),
      .col(col_b), .row(row_b), .win_de(win_de_b), .win_valid(win_valid_b),
      .win_edge(win_edge_b), .sof(sof_b), .eof(eof_b), .sol(sol_b), .eol(eol_b),
      .line_err(line_err_b), .frame_err(frame_err_b)
   );

   typedef struct {
      int vs, de, wde, col, row;
      logic [3:0] edg;
      int valid, sol, eol, lerr, ferr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step_a(input logic vs, input logic de);
      @(negedge clock);
      vs_a = vs;
      de_a = de;
      @(posedge clock);
      #1;
   endtask

   task automatic step_b(input logic vs, input logic de);
      @(negedge clock);
      vs_b = vs;
      de_b = de;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_win_de"},    32'(win_de_a), 0);
      chk({tag, "_col"},       32'(col_a), 0);
      chk({tag, "_row"},       32'(row_a), 0);
      chk({tag, "_win_edge"},  32'(win_edge_a), 0);
      chk({tag, "_pulses"},    32'({sof_a, eof_a, sol_a, eol_a, win_valid_a}), 0);
      chk({tag, "_errs"},      32'({line_err_a, frame_err_a}), 0);
   endtask

   // Expected outputs of instance a for pixel p of line l (col saturates at 15).
   task automatic chk_pix_a(input int p, input int l);
      int c;
      logic [3:0] e;
      c = (p > 15) ? 15 : p;
      e = {l > 3, l < 2, c > 5, c < 2};
      chk("a_win_de",    32'(win_de_a), 1);
      chk("a_col",       32'(col_a), 32'(c));
      chk("a_row",       32'(row_a), 32'(l));
      chk("a_win_edge",  32'(win_edge_a), 32'(e));
      chk("a_win_valid", 32'(win_valid_a), 32'(e == 4'b0000));
      chk("a_sol",       32'(sol_a), 32'(p == 0));
      chk("a_eol",       32'(eol_a), 32'(c == 7));
      chk("a_sof",       32'(sof_a), 32'(p == 0 && l == 0));
      chk("a_eof",       32'(eof_a), 32'(c == 7 && l == 5));
      if (win_valid_a) valid_cnt++;
   endtask

   task automatic run_line_a(input int l, input int len);
      for (int p = 0; p < len; p++) begin
         step_a(1'b0, 1'b1);
         chk_pix_a(p, l);
      end
      step_a(1'b0, 1'b0);
      chk("a_line_err",  32'(line_err_a), 32'(len != 8));
      chk("a_hb_win_de", 32'(win_de_a), 0);
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b0);
   endtask

   // Opens a frame with a vs pulse; exp_ferr judges the frame that just ended.
   task automatic frame_a(input int nlines, input int short_l, input int short_len,
                          input logic exp_ferr);
      step_a(1'b1, 1'b0);
      chk("a_frame_err", 32'(frame_err_a), 32'(exp_ferr));
      chk("a_vs_win_de", 32'(win_de_a), 0);
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b0);
      valid_cnt = 0;
      for (int l = 0; l < nlines; l++) begin
         run_line_a(l, (l == short_l) ? short_len : 8);
      end
   endtask

   initial begin
      // 3x3 window on 4x4: edge = {bottom,top,right,left}
      tbl.push_back(vec_t'{1,0, 0,0,0, 4'b0000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,0,0, 4'b0101, 0,1,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,1,0, 4'b0100, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,2,0, 4'b0100, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,3,0, 4'b0110, 0,0,1, 0,0});
      tbl.push_back(vec_t'{0,0, 0,0,0, 4'b0000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,0,1, 4'b0001, 0,1,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,1,1, 4'b0000, 1,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,2,1, 4'b0000, 1,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,3,1, 4'b0010, 0,0,1, 0,0});
      tbl.push_back(vec_t'{0,0, 0,0,0, 4'b0000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,0,2, 4'b0001, 0,1,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,1,2, 4'b0000, 1,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,2,2, 4'b0000, 1,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,3,2, 4'b0010, 0,0,1, 0,0});
      tbl.push_back(vec_t'{0,0, 0,0,0, 4'b0000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,0,3, 4'b1001, 0,1,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,1,3, 4'b1000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,2,3, 4'b1000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{0,1, 1,3,3, 4'b1010, 0,0,1, 0,0});
      tbl.push_back(vec_t'{0,0, 0,0,0, 4'b0000, 0,0,0, 0,0});
      tbl.push_back(vec_t'{1,0, 0,0,0, 4'b0000, 0,0,0, 0,0});

      // Reset state
      @(negedge clock);
      @(negedge clock);
      chk_zero_a("rst");
      chk("rst_b_win_de", 32'(win_de_b), 0);
      chk("rst_b_col_row", 32'({col_b, row_b}), 0);
      rst_n = 1'b1;
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b0);

      // T1 nominal frame, first after reset
      frame_a(6, -1, 0, 1'b0);
      chk("t1_valid_cnt", 32'(valid_cnt), 8);
      // T2 short line 3
      frame_a(6, 3, 7, 1'b0);
      // T3 short frame (its vs also shows T2 ended with 6 rows)
      frame_a(5, -1, 0, 1'b0);

      // T5: vs together with de mid-line
      step_a(1'b1, 1'b0);
      chk("t3_frame_err", 32'(frame_err_a), 1);
      step_a(1'b0, 1'b0);
      run_line_a(0, 8);
      for (int p = 0; p < 4; p++) begin
         step_a(1'b0, 1'b1);
         chk_pix_a(p, 1);
      end
      step_a(1'b1, 1'b1);
      chk("t5_line_err", 32'(line_err_a), 1);
      chk("t5_win_de",   32'(win_de_a), 1);
      chk("t5_sof",      32'(sof_a), 1);
      chk("t5_sol",      32'(sol_a), 1);
      chk("t5_col",      32'(col_a), 0);
      chk("t5_row",      32'(row_a), 0);
      for (int p = 1; p < 8; p++) begin
         step_a(1'b0, 1'b1);
         chk_pix_a(p, 0);
      end
      step_a(1'b0, 1'b0);
      chk("t5_close_line_err", 32'(line_err_a), 0);
      step_a(1'b0, 1'b0);
      // Overlong line: col saturates at 15, line_err on the fall
      run_line_a(1, 18);
      for (int l = 2; l < 6; l++) run_line_a(l, 8);

      // T4: asynchronous reset at col=4, row=2
      step_a(1'b1, 1'b0);
      chk("t4_prev_frame_err", 32'(frame_err_a), 0);
      step_a(1'b0, 1'b0);
      run_line_a(0, 8);
      run_line_a(1, 8);
      for (int p = 0; p < 5; p++) begin
         step_a(1'b0, 1'b1);
         chk_pix_a(p, 2);
      end
      #2 rst_n = 1'b0;
      #1 chk_zero_a("t4_async");
      @(negedge clock);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_a(1'b0, 1'b1);
         chk("t4_idle_win_de", 32'(win_de_a), 0);
         chk("t4_idle_sol",    32'(sol_a), 0);
      end
      step_a(1'b0, 1'b0);
      step_a(1'b1, 1'b0);
      chk("t4_first_frame_err", 32'(frame_err_a), 0);
      step_a(1'b0, 1'b0);
      step_a(1'b0, 1'b1);
      chk("t4_win_de", 32'(win_de_a), 1);
      chk("t4_col",    32'(col_a), 0);
      chk("t4_row",    32'(row_a), 0);
      chk("t4_sof",    32'(sof_a), 1);
      step_a(1'b0, 1'b0);

      // T6: table-driven 4x4 frame on instance b
      foreach (tbl[i]) begin
         step_b(tbl[i].vs != 0, tbl[i].de != 0);
         chk("b_win_de",    32'(win_de_b), 32'(tbl[i].wde));
         chk("b_win_edge",  32'(win_edge_b), 32'(tbl[i].edg));
         chk("b_win_valid", 32'(win_valid_b), 32'(tbl[i].valid));
         chk("b_sol",       32'(sol_b), 32'(tbl[i].sol));
         chk("b_eol",       32'(eol_b), 32'(tbl[i].eol));
         chk("b_line_err",  32'(line_err_b), 32'(tbl[i].lerr));
         chk("b_frame_err", 32'(frame_err_b), 32'(tbl[i].ferr));
         if (tbl[i].wde != 0) begin
            chk("b_col", 32'(col_b), 32'(tbl[i].col));
            chk("b_row", 32'(row_b), 32'(tbl[i].row));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
